writeback_controller: RTL
=========================

Name: writeback_controller

Overview:
- Write-side counterpart of the read-register decoding path.
- Decides the destination register, data and write enable for the single register-file write port.
- Merges two sources: in-order pipeline results from the MEM/WB stage and asynchronous completions from the multi-cycle mult/div unit.
- Keeps a pending-destination scoreboard so the decode stage can stall on registers the mult/div unit has not yet written.

Parameters:
- RSTATUS_REG, 30: register written with exception status.
- LINK_REG, 31: register written by jal.
- MULT_EXC_CODE, 4: rstatus value on a mult overflow.
- DIV_EXC_CODE, 5: rstatus value on a divide-by-zero.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  WB-stage instruction is valid
- wb_instruction  in  32  WB-stage instruction word
- wb_data  in  32  ALU/load/link result for the WB instruction
- md_issue  in  1  mult/div issued this cycle
- md_dest  in  5  destination register of the issued mult/div
- md_is_div  in  1  issued op is a div (latched with md_issue)
- md_done  in  1  mult/div result valid (1-cycle pulse)
- md_result  in  32  mult/div result
- md_exception  in  1  overflow / divide-by-zero, qualified by md_done
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- pending_mask  out  32  bit i set = register i awaits a mult/div write
- md_busy  out  1  mult/div destination outstanding; issue logic must not assert md_issue

Behaviour:
- Opcode field is instruction[31:27]; rd field is [26:22].
- WB-side write decode (pure combinational from wb_instruction):
  - 00000 R-type, 00101 addi, 01000 lw: write rd.
  - 00011 jal: write LINK_REG.
  - 10101 setx: write RSTATUS_REG with zero-extended instruction[26:0].
  - All other opcodes: no write.
  - Any write to register 0 is suppressed.
  - R-type with ALU op mul/div (instruction[6:2] = 00110/00111) does not write from WB; that write comes from md_done.
- Outputs are registered, with one-cycle latency from the accepted source to rf_we/rf_waddr/rf_wdata.
- Reset (asynchronous, active-low): rf_we=0, rf_waddr=0, rf_wdata=0, pending_mask=0, md_busy=0, hold buffer empty, state IDLE.
- State machine:
  - IDLE: no mult/div outstanding.
    - md_issue with md_dest≠0 → PENDING: latch md_dest and md_is_div, set pending_mask[md_dest], md_busy=1.
    - md_issue with md_dest=0: the op still runs, but state stays IDLE and no mask bit is set.
  - PENDING, on md_done:
    - No WB write this cycle: write md_result (or the exception code to RSTATUS_REG) next cycle, clear the mask bit → IDLE.
    - WB write this cycle: WB wins the port; capture the result in the 1-entry hold buffer → HOLD.
  - HOLD:
    - Next cycle with no WB write: drain the hold buffer, clear the mask bit → IDLE.
    - WB write present: stay in HOLD; WB still has priority.
- Exception: on md_exception, write RSTATUS_REG with MULT_EXC_CODE or DIV_EXC_CODE; the latched md_dest is not written; the md_dest mask bit is still cleared.
- WB writing a register whose pending bit is set: the write proceeds; the later mult/div write overwrites it (program order is guaranteed by decode stalling on pending_mask).
- Protocol errors:
  - md_issue while md_busy=1 is a protocol violation; the input is ignored and the bench flags it.
  - md_done in IDLE is ignored.
- md_busy stays 1 through HOLD and drops in the cycle the buffered result is written.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_SETX.
  - ALU op constants: ALU_MUL, ALU_DIV.
  - a typedef for the 3-state enum IDLE/PENDING/HOLD.
  - exception-code constants.
- One natural sub-module: write_register_decoder. It is combinational; it maps an instruction to {we, waddr, data_select} and is reused by hazard logic.

Test Plan:
- Reset mid-PENDING: md_issue(dest=7), then reset low → pending_mask=0, md_busy=0, rf_we=0 asynchronously; no write after release.
- addi rd=5 with wb_data=0x12 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12; lw rd=0 → rf_we stays 0.
- jal with wb_data=0x40 → rf_waddr=31, rf_wdata=0x40; setx T=0x3 → rf_waddr=30, rf_wdata=0x3.
- md_issue(dest=9); 10 cycles later md_done with result 0xABCD and no WB → pending_mask[9]=1 during wait; next cycle rf_waddr=9, rf_wdata=0xABCD, then mask=0, md_busy=0.
- Collision: md_done(result 0x55, dest=9) in the same cycle as addi rd=4 → cycle+1 writes r4; cycle+2 writes r9=0x55. With back-to-back WB writes, r9 waits until the first WB-free cycle.
- Div exception: issue div dest=3, then md_done with md_exception=1 → r30=5 written, r3 untouched, pending_mask[3] cleared.

Source files
------------

// File: rtl/writeback_controller_pkg.sv
// Shared constants and types for the register-file writeback path:
// opcode/ALU encodings, special registers, exception codes and the FSM state type.
package writeback_controller_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [4:0] RSTATUS_REG = 5'd30;
    localparam logic [4:0] LINK_REG    = 5'd31;

    localparam logic [31:0] MULT_EXC_CODE = 32'd4;
    localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

    // Data source selected by the write decoder for a WB-side write
    localparam logic SEL_WB_DATA  = 1'b0;
    localparam logic SEL_SETX_IMM = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOLD    = 2'd2
    } wb_state_t;

    function automatic logic [31:0] exc_code(input logic is_div);
        return is_div ? DIV_EXC_CODE : MULT_EXC_CODE;
    endfunction

endpackage

// File: rtl/writeback_controller_write_register_decoder.sv
// Combinational decode of which register (if any) an instruction writes at WB.
// Mult/div R-types report no write here; their result arrives later from the mult/div unit.
module write_register_decoder
    import writeback_controller_pkg::*;
(
    input  logic [31:0] instruction,
    output logic        we,
    output logic [4:0]  waddr,
    output logic        data_select
);

    logic [4:0] opcode;
    logic [4:0] alu_op;
    logic       unused_bits;

    assign opcode      = instruction[31:27];
    assign alu_op      = instruction[6:2];
    assign unused_bits = ^{instruction[21:7], instruction[1:0]};

    always_comb begin
        we          = 1'b0;
        waddr       = instruction[26:22];
        data_select = SEL_WB_DATA;
        case (opcode)
            OP_RTYPE: we = !((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
            OP_ADDI,
            OP_LW:    we = 1'b1;
            OP_JAL: begin
                we    = 1'b1;
                waddr = LINK_REG;
            end
            OP_SETX: begin
                we          = 1'b1;
                waddr       = RSTATUS_REG;
                data_select = SEL_SETX_IMM;
            end
            default:  we = 1'b0;
        endcase
        // r0 is hardwired to zero, so any write aimed at it is dropped
        if (waddr == 5'd0) begin
            we = 1'b0;
        end
    end

endmodule

// File: rtl/writeback_controller.sv
// Single register-file write port arbiter: in-order WB results take priority,
// mult/div completions are written when the port is free, buffered for at most one entry.
module writeback_controller
    import writeback_controller_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_instruction,
    input  logic [31:0] wb_data,
    input  logic        md_issue,
    input  logic [4:0]  md_dest,
    input  logic        md_is_div,
    input  logic        md_done,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending_mask,
    output logic        md_busy
);

    wb_state_t   state;
    wb_state_t   next_state;

    logic [4:0]  dest_q;
    logic        is_div_q;
    logic [4:0]  hold_addr;
    logic [31:0] hold_data;

    logic        dec_we;
    logic [4:0]  dec_waddr;
    logic        dec_sel;
    logic        wb_write;
    logic [31:0] wb_value;
    logic [4:0]  md_addr;
    logic [31:0] md_value;

    logic        md_accept;
    logic        md_retire;
    logic        hold_capture;
    logic        next_we;
    logic [4:0]  next_waddr;
    logic [31:0] next_wdata;
    logic [31:0] next_mask;

    write_register_decoder u_decoder (
        .instruction (wb_instruction),
        .we          (dec_we),
        .waddr       (dec_waddr),
        .data_select (dec_sel)
    );

    assign wb_write = wb_valid && dec_we;
    assign wb_value = (dec_sel == SEL_SETX_IMM) ? {5'b0, wb_instruction[26:0]} : wb_data;

    // A faulting mult/div reports into rstatus instead of its own destination
    assign md_addr  = md_exception ? RSTATUS_REG : dest_q;
    assign md_value = md_exception ? exc_code(is_div_q) : md_result;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (md_issue && (md_dest != 5'd0)) begin
                    next_state = PENDING;
                end
            end
            PENDING: begin
                if (md_done) begin
                    next_state = wb_write ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!wb_write) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        md_accept    = 1'b0;
        md_retire    = 1'b0;
        hold_capture = 1'b0;
        next_we      = 1'b0;
        next_waddr   = 5'd0;
        next_wdata   = 32'd0;
        md_busy      = (state != IDLE);
        case (state)
            IDLE: md_accept = md_issue && (md_dest != 5'd0);
            PENDING: begin
                if (md_done && wb_write) begin
                    hold_capture = 1'b1;
                end else if (md_done) begin
                    md_retire  = 1'b1;
                    next_we    = 1'b1;
                    next_waddr = md_addr;
                    next_wdata = md_value;
                end
            end
            HOLD: begin
                if (!wb_write) begin
                    md_retire  = 1'b1;
                    next_we    = 1'b1;
                    next_waddr = hold_addr;
                    next_wdata = hold_data;
                end
            end
            default: md_retire = 1'b0;
        endcase
        if (wb_write) begin
            next_we    = 1'b1;
            next_waddr = dec_waddr;
            next_wdata = wb_value;
        end
        next_mask = pending_mask;
        if (md_accept) begin
            next_mask[md_dest] = 1'b1;
        end
        if (md_retire) begin
            next_mask[dest_q] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            rf_wdata     <= 32'd0;
            pending_mask <= 32'd0;
            dest_q       <= 5'd0;
            is_div_q     <= 1'b0;
            hold_addr    <= 5'd0;
            hold_data    <= 32'd0;
        end else begin
            rf_we        <= next_we;
            rf_waddr     <= next_waddr;
            rf_wdata     <= next_wdata;
            pending_mask <= next_mask;
            if (md_accept) begin
                dest_q   <= md_dest;
                is_div_q <= md_is_div;
            end
            if (hold_capture) begin
                hold_addr <= md_addr;
                hold_data <= md_value;
            end
        end
    end

endmodule
